// File: rtl/spi_pkg.sv
// Shared encodings for the parametrised SPI master.
//   ST_IDLE..ST_TRAIL : FSM state codes, also visible on the debug 'state' port
//   MODE0..MODE3      : SPI mode numbers as {CPOL, CPHA}
//   spi_mode_t        : clock mode captured when a transfer is accepted
package spi_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEAD  = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_TRAIL = 2'd3;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period divider.
//   clk, reset    : system clock, synchronous active-high reset
//   run           : transfer active (LEAD/XFER/TRAIL); divider held at 0 otherwise
//   xfer          : XFER phase; the SCLK edge counter only advances here
//   half_end_c    : last clk cycle of the current half-period
//   lead_stb_c    : half-period end that is followed by a leading SCLK edge
//   trail_stb_c   : half-period end that is followed by a trailing SCLK edge
//   edge_cnt      : SCLK edges already produced in this transfer
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DATA_W  = 8,
  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1,
  localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              xfer,
  output logic              half_end_c,
  output logic              lead_stb_c,
  output logic              trail_stb_c,
  output logic [EDGE_W-1:0] edge_cnt
);

  logic [DIV_W-1:0] div_cnt;

  assign half_end_c  = run && (div_cnt == DIV_W'(CLK_DIV - 1));
  // Edges are numbered from 1, odd ones are leading: an even count means the next edge leads.
  assign lead_stb_c  = xfer && half_end_c && !edge_cnt[0];
  assign trail_stb_c = xfer && half_end_c &&  edge_cnt[0];

  // Cycle divider and edge counter
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      div_cnt <= (!run || half_end_c) ? '0 : div_cnt + DIV_W'(1);
      if (!xfer)
        edge_cnt <= '0;
      else if (half_end_c)
        edge_cnt <= edge_cnt + EDGE_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: four CPOL/CPHA modes, DATA_W-bit full-duplex words,
// NUM_CS active-low chip selects, start/busy/done handshake.
//   clk, reset   : system clock, synchronous active-high reset
//   start        : transfer request, accepted only in IDLE
//   cs_sel       : slave index; out-of-range index runs with every cs_n high
//   polarity     : CPOL (also drives idle SCLK level)
//   phase        : CPHA
//   data_wr      : TX word
//   miso         : serial data from slave
//   spi_clk      : SCLK
//   cs_n         : active-low chip selects
//   mosi         : serial data to slave
//   data_rd      : RX word, updated together with done
//   busy         : transfer in progress
//   done         : one-cycle end-of-transfer pulse
//   state        : debug view of the FSM state
module spi_master_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned NUM_CS    = 2,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              polarity,
  input  logic              phase,
  input  logic [DATA_W-1:0] data_wr,
  input  logic              miso,
  output logic              spi_clk,
  output logic [NUM_CS-1:0] cs_n,
  output logic              mosi,
  output logic [DATA_W-1:0] data_rd,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state
);

  localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);

  logic [DATA_W-1:0] tx_sr, tx_sr_nx;
  logic [DATA_W-1:0] rx_sr, rx_sr_nx;
  spi_mode_t         mode, mode_nx;
  logic [1:0]        state_nx;
  logic              spi_clk_nx, mosi_nx, busy_nx, done_nx;
  logic [NUM_CS-1:0] cs_n_nx, cs_dec_c;
  logic [DATA_W-1:0] data_rd_nx;

  logic              half_end_c, lead_stb_c, trail_stb_c, last_edge_c;
  logic [EDGE_W-1:0] edge_cnt;

  // Next bit on the wire and the word left after it has gone out
  function automatic logic tx_head(input logic [DATA_W-1:0] d);
    return MSB_FIRST ? d[DATA_W-1] : d[0];
  endfunction

  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] d);
    return MSB_FIRST ? {d[DATA_W-2:0], 1'b0} : {1'b0, d[DATA_W-1:1]};
  endfunction

  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] d, input logic b);
    return MSB_FIRST ? {d[DATA_W-2:0], b} : {b, d[DATA_W-1:1]};
  endfunction

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W)
  ) u_clk_gen (
    .clk         (clk),
    .reset       (reset),
    .run         (state != ST_IDLE),
    .xfer        (state == ST_XFER),
    .half_end_c  (half_end_c),
    .lead_stb_c  (lead_stb_c),
    .trail_stb_c (trail_stb_c),
    .edge_cnt    (edge_cnt)
  );

  assign last_edge_c = (edge_cnt == EDGE_W'(2 * DATA_W - 1));

  // One-hot active-low select decode; out-of-range index selects nothing
  always_comb begin
    cs_dec_c = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (cs_sel == CS_W'(i)) cs_dec_c[i] = 1'b0;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nx   = state;
    spi_clk_nx = spi_clk;
    cs_n_nx    = cs_n;
    mosi_nx    = mosi;
    data_rd_nx = data_rd;
    busy_nx    = busy;
    done_nx    = 1'b0;
    tx_sr_nx   = tx_sr;
    rx_sr_nx   = rx_sr;
    mode_nx    = mode;
    case (state)
      ST_IDLE: begin
        spi_clk_nx = polarity;
        if (start) begin
          state_nx = ST_LEAD;
          busy_nx  = 1'b1;
          mode_nx  = '{cpol: polarity, cpha: phase};
          cs_n_nx  = cs_dec_c;
          rx_sr_nx = '0;
          // CPHA=0 presents the first bit before the first SCLK edge
          if (!phase) begin
            mosi_nx  = tx_head(data_wr);
            tx_sr_nx = tx_shift(data_wr);
          end else begin
            tx_sr_nx = data_wr;
          end
        end
      end
      ST_LEAD: begin
        spi_clk_nx = mode.cpol;
        if (half_end_c) state_nx = ST_XFER;
      end
      ST_XFER: begin
        if (half_end_c) spi_clk_nx = ~spi_clk;
        if (lead_stb_c) begin
          if (mode.cpha) begin
            mosi_nx  = tx_head(tx_sr);
            tx_sr_nx = tx_shift(tx_sr);
          end else begin
            rx_sr_nx = rx_shift(rx_sr, miso);
          end
        end
        if (trail_stb_c) begin
          if (mode.cpha) begin
            rx_sr_nx = rx_shift(rx_sr, miso);
          end else if (!last_edge_c) begin
            mosi_nx  = tx_head(tx_sr);
            tx_sr_nx = tx_shift(tx_sr);
          end
          if (last_edge_c) state_nx = ST_TRAIL;
        end
      end
      ST_TRAIL: begin
        spi_clk_nx = mode.cpol;
        if (half_end_c) begin
          state_nx   = ST_IDLE;
          busy_nx    = 1'b0;
          done_nx    = 1'b1;
          cs_n_nx    = '1;
          data_rd_nx = rx_sr;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      spi_clk <= 1'b0;
      cs_n    <= '1;
      mosi    <= 1'b0;
      data_rd <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      mode    <= '0;
    end else begin
      state   <= state_nx;
      spi_clk <= spi_clk_nx;
      cs_n    <= cs_n_nx;
      mosi    <= mosi_nx;
      data_rd <= data_rd_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      tx_sr   <= tx_sr_nx;
      rx_sr   <= rx_sr_nx;
      mode    <= mode_nx;
    end
  end

endmodule
